// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: cooldown, LFSR-seeded round-robin pick of a living enemy, valid/ready issue, bullet slot pool.
// Optional ADAPTIVE_RATE_EN: cooldown reload shrinks with each dead enemy, floored at RATE_MIN.
module enemy_fire_scheduler #(
    parameter int N_ENEMY     = 24,
    parameter int N_SLOTS     = 3,
    parameter int ATRASO_TIRO = 1000000
`ifdef ADAPTIVE_RATE_EN
    ,
    parameter int RATE_STEP   = 32768,
    parameter int RATE_MIN    = 200000
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_ENEMY-1:0]           enemy_vivos,
    input  logic                         enable,
    input  logic                         fire_ready,
    input  logic                         bullet_done,
    output logic                         fire_valid,
    output logic [$clog2(N_ENEMY)-1:0]   fire_id,
    output logic [N_ENEMY-1:0]           ID_enemy_tiro,
    output logic [$clog2(N_SLOTS+1)-1:0] active_shots
);
    localparam int IDW = $clog2(N_ENEMY);
    localparam int SW  = $clog2(N_SLOTS + 1);
    localparam int CW  = 25;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {IDLE, PICK, SCAN, ISSUE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cd_q;
    logic [CW-1:0]    reload;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   scan_q;
    logic [IDW-1:0]   fire_id_q;
    logic             fire_valid_q;
    logic [N_ENEMY-1:0] tiro_q;
    logic [SW-1:0]    shots_q;
    logic             handshake;

    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
    assign handshake = fire_valid_q & fire_ready;

`ifdef ADAPTIVE_RATE_EN
    // Compare the cut against the headroom above the floor so the subtraction never wraps.
    localparam int unsigned FLOOR_GAP = (ATRASO_TIRO > RATE_MIN) ? ATRASO_TIRO - RATE_MIN : 0;
    logic [31:0] alive_cnt;
    logic [31:0] cut;
    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < N_ENEMY; i++)
            alive_cnt = alive_cnt + 32'(enemy_vivos[i]);
        cut    = (32'(N_ENEMY) - alive_cnt) * 32'(RATE_STEP);
        reload = (cut >= FLOOR_GAP) ? CW'(RATE_MIN) : CW'(32'(ATRASO_TIRO) - cut);
    end
`else
    assign reload = CW'(ATRASO_TIRO);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cd_q         <= CW'(ATRASO_TIRO);
            lfsr_q       <= LFSR_SEED;
            ptr_q        <= '0;
            scan_q       <= '0;
            fire_id_q    <= '0;
            fire_valid_q <= 1'b0;
            tiro_q       <= '0;
            shots_q      <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            tiro_q <= '0;
            // A shot leaving and one entering in the same cycle cancel out.
            if (handshake && !bullet_done)
                shots_q <= shots_q + SW'(1);
            else if (!handshake && bullet_done && shots_q != '0)
                shots_q <= shots_q - SW'(1);

            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (cd_q != '0)
                            cd_q <= cd_q - CW'(1);
                        else if (shots_q < SW'(N_SLOTS))
                            state_q <= PICK;
                    end
                end
                PICK: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else begin
                        ptr_q   <= IDW'(lfsr_q % 16'(N_ENEMY));
                        scan_q  <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (enemy_vivos[ptr_q]) begin
                        fire_id_q    <= ptr_q;
                        fire_valid_q <= 1'b1;
                        state_q      <= ISSUE;
                    end else if (scan_q == IDW'(N_ENEMY - 1)) begin
                        cd_q    <= reload;
                        state_q <= IDLE;
                    end else begin
                        ptr_q  <= (ptr_q == IDW'(N_ENEMY - 1)) ? '0 : ptr_q + IDW'(1);
                        scan_q <= scan_q + IDW'(1);
                    end
                end
                ISSUE: begin
                    // Once raised, the request stays up regardless of enable or the target dying.
                    if (handshake) begin
                        fire_valid_q <= 1'b0;
                        tiro_q       <= N_ENEMY'(1) << fire_id_q;
                        cd_q         <= reload;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fire_valid    = fire_valid_q;
    assign fire_id       = fire_id_q;
    assign ID_enemy_tiro = tiro_q;
    assign active_shots  = shots_q;
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench for enemy_fire_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_enemy_fire_scheduler;
    localparam int N     = 8;
    localparam int SLOTS = 2;
`ifdef ADAPTIVE_RATE_EN
    localparam int DLY  = 100;
    localparam int STEP = 10;
    localparam int RMIN = 40;
`else
    localparam int DLY  = 8;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] enemy_vivos;
    logic         enable, fire_ready, bullet_done;
    logic         fire_valid;
    logic [2:0]   fire_id;
    logic [N-1:0] ID_enemy_tiro;
    logic [1:0]   active_shots;

    enemy_fire_scheduler #(
        .N_ENEMY(N), .N_SLOTS(SLOTS), .ATRASO_TIRO(DLY)
`ifdef ADAPTIVE_RATE_EN
        , .RATE_STEP(STEP), .RATE_MIN(RMIN)
`endif
    ) dut (
        .clk(clk), .reset(reset), .enemy_vivos(enemy_vivos), .enable(enable),
        .fire_ready(fire_ready), .bullet_done(bullet_done), .fire_valid(fire_valid),
        .fire_id(fire_id), .ID_enemy_tiro(ID_enemy_tiro), .active_shots(active_shots)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: what the scheduler should be doing this cycle.
    logic [15:0]  m_lfsr;
    int           m_cd, m_scan, m_base, m_id, m_shots, idx;
    bit           m_pend, acc;
    logic [N-1:0] m_pulse;
    int           exp_q[$];

    function automatic int reload_of(input logic [N-1:0] v);
`ifdef ADAPTIVE_RATE_EN
        int r;
        r = DLY - (N - $countones(v)) * STEP;
        return (r < RMIN) ? RMIN : r;
`else
        return DLY;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_lfsr = 16'hACE1; m_cd = DLY; m_scan = -1; m_pend = 0;
            m_shots = 0; m_pulse = '0; exp_q.delete();
        end else begin
            m_pulse = '0;
            acc = m_pend && fire_ready;
            if (m_pend) begin
                if (acc) begin
                    m_pend = 0; m_pulse = N'(1) << m_id; m_cd = reload_of(enemy_vivos);
                end
            end else if (m_scan >= 0) begin
                // m_scan: 0 = choosing start point, k>=1 = k-th enemy being examined
                if (!enable) m_scan = -1;
                else if (m_scan == 0) begin m_base = m_lfsr % N; m_scan = 1; end
                else begin
                    idx = (m_base + m_scan - 1) % N;
                    if (enemy_vivos[idx]) begin
                        m_pend = 1; m_id = idx; m_scan = -1; exp_q.push_back(idx);
                    end else if (m_scan == N) begin
                        m_scan = -1; m_cd = reload_of(enemy_vivos);
                    end else m_scan++;
                end
            end else if (enable) begin
                if (m_cd > 0) m_cd--;
                else if (m_shots < SLOTS) m_scan = 0;
            end
            if (acc && !bullet_done) m_shots++;
            else if (!acc && bullet_done && m_shots > 0) m_shots--;
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
        end
    end

    // Monitor: compares every cycle, pops the scoreboard when a request appears.
    bit mon_on = 0;
    bit prev_valid = 0;
    int n_issue = 0;
    int exp_id;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid", int'(fire_valid), int'(m_pend));
            chk("active_shots", int'(active_shots), m_shots);
            chk("tiro_pulse", int'(ID_enemy_tiro), int'(m_pulse));
            if (fire_valid) begin
                if (!prev_valid) begin
                    n_issue++;
                    chk("issue_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_id = exp_q.pop_front();
                        chk("issue_id", int'(fire_id), exp_id);
                    end
                end
                chk("id_hold", int'(fire_id), m_id);
            end
            prev_valid = fire_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(2); reset = 1'b0;
    endtask

    // sel 0: fire_valid high; sel 1: active_shots == 1
    task automatic wait_for(input int sel, input int bound, input string nm);
        int k = 0;
        while (!(sel == 0 ? fire_valid : active_shots == 2'd1) && k < bound) begin
            step(1); k++;
        end
        chk(nm, int'(sel == 0 ? fire_valid : active_shots == 2'd1), 1);
    endtask

    int rise, base, cnt, hold_id;

    initial begin
        reset = 1'b1; enemy_vivos = '1; enable = 1'b1; fire_ready = 1'b1; bullet_done = 1'b0;
        step(1);
        mon_on = 1;

        // First shot latency, then slot pool fills and stalls
        do_reset();
        base = n_issue; rise = -1;
        for (int k = 1; k <= DLY + 30; k++) begin
            step(1);
            if (fire_valid) begin rise = k; break; end
        end
        chk("first_issue_latency", rise, DLY + 3);
        step(1);
        chk("shots_after_first", int'(active_shots), 1);
        step(3 * (DLY + N + 4));
        chk("slots_full_count", n_issue - base, 2);
        chk("slots_full_no_valid", int'(fire_valid), 0);
        bullet_done = 1'b1; step(1); bullet_done = 1'b0;
        wait_for(0, N + 8, "third_shot_timeout");
        step(1);
        chk("third_shot_count", n_issue - base, 3);

        // Lone survivor always fires; nobody alive never fires
        do_reset();
        enemy_vivos = 8'b0010_0000; base = n_issue;
        for (int k = 0; k < 6 * (DLY + 2 * N); k++) begin
            bullet_done = ($urandom_range(0, 3) == 0);
            step(1);
            if (fire_valid) chk("only5_id", int'(fire_id), 5);
        end
        chk("only5_fired", int'(n_issue > base), 1);
        enemy_vivos = '0; step(N + 3); cnt = 0;
        for (int k = 0; k < 100; k++) begin
            bullet_done = ($urandom_range(0, 3) == 0);
            step(1);
            if (fire_valid) cnt++;
        end
        bullet_done = 1'b0;
        chk("all_dead_no_fire", cnt, 0);

        // Back-pressure with the target dying meanwhile
        do_reset();
        enemy_vivos = '1; fire_ready = 1'b0;
        wait_for(0, DLY + N + 10, "stall_issue_timeout");
        hold_id = int'(fire_id);
        enemy_vivos[fire_id] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (fire_valid && int'(fire_id) == hold_id) cnt++;
        end
        chk("hold_stable_cycles", cnt, 20);
        fire_ready = 1'b1; step(1);
        chk("stalled_shot_pulse", int'(ID_enemy_tiro), int'(N'(1) << hold_id));

        // Handshake and bullet_done together; bullet_done at zero
        do_reset();
        enemy_vivos = '1;
        wait_for(1, DLY + N + 10, "one_shot_timeout");
        fire_ready = 1'b0;
        wait_for(0, DLY + N + 10, "second_issue_timeout");
        fire_ready = 1'b1; bullet_done = 1'b1; step(1); bullet_done = 1'b0;
        chk("hs_and_done", int'(active_shots), 1);
        do_reset();
        bullet_done = 1'b1; step(1); bullet_done = 1'b0;
        chk("done_at_zero", int'(active_shots), 0);

        // enable drop mid-scan, then retry once enable returns
        do_reset();
        enemy_vivos = 8'b0000_0001;
        step(DLY + 2);
        enable = 1'b0; step(6);
        chk("abort_no_valid", int'(fire_valid), 0);
        enable = 1'b1;
        wait_for(0, N + 8, "retry_timeout");
        chk("retry_id", int'(fire_id), 0);

        // Reset while a request is pending
        fire_ready = 1'b0; step(2);
        reset = 1'b1; step(1);
        chk("reset_drops_valid", int'(fire_valid), 0);
        chk("reset_clears_shots", int'(active_shots), 0);
        reset = 1'b0; fire_ready = 1'b1; enemy_vivos = '1;

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            enable      = ($urandom_range(0, 9) != 0);
            fire_ready  = ($urandom_range(0, 2) != 0);
            bullet_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) enemy_vivos = N'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            step(1);
        end
        reset = 1'b0; step(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
- Decides which living enemy fires next and when, sharing a limited pool of enemy-bullet slots among all enemies.
- Sits between the game engine (alive mask, run/pause) and the enemy-bullet datapath.
- Uses a cooldown timer, LFSR-seeded pick with round-robin scan to the next alive enemy, and a valid/ready issue handshake.
- Returns slots when bullets finish.

Parameters:
- N_ENEMY, 24, number of enemies; width of alive mask and one-hot output.
- N_SLOTS, 3, max simultaneous enemy bullets.
- ATRASO_TIRO, 1000000, cooldown cycles between shots; counter is 25 bits.
- RATE_STEP, 32768, cooldown reduction per dead enemy (ADAPTIVE_RATE_EN only).
- RATE_MIN, 200000, cooldown floor (ADAPTIVE_RATE_EN only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enemy_vivos  in  N_ENEMY  bit i = 1: enemy i alive
- enable  in  1  1 = game running (estado_jogo == 0); 0 = frozen
- fire_ready  in  1  bullet datapath accepts a shot
- bullet_done  in  1  one-cycle pulse: one enemy bullet left play
- fire_valid  out  1  shot request pending
- fire_id  out  5  index of firing enemy (clog2(N_ENEMY))
- ID_enemy_tiro  out  N_ENEMY  one-hot, one-cycle pulse on accepted shot
- active_shots  out  2  bullets in flight (clog2(N_SLOTS+1))

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values:
  - Outputs: fire_valid = 0, fire_id = 0, ID_enemy_tiro = 0, active_shots = 0.
  - Internal: state = IDLE, cooldown = ATRASO_TIRO, LFSR = 16'hACE1.
- LFSR: 16-bit Galois, mask 16'hB400; advances every cycle, including when enable = 0.
- IDLE:
  - enable = 1 and cooldown != 0: cooldown decrements by 1.
  - cooldown == 0, enable = 1 and active_shots < N_SLOTS: go to PICK.
  - Cooldown expired but slots full: hold at 0 until a slot frees.
- PICK (1 cycle): ptr = LFSR % N_ENEMY; scan_cnt = 0; go to SCAN.
- SCAN (one enemy per cycle):
  - enemy_vivos[ptr] = 1: fire_id = ptr; go to ISSUE.
  - Otherwise: ptr = (ptr == N_ENEMY-1) ? 0 : ptr+1; scan_cnt++.
  - scan_cnt reaches N_ENEMY with no hit: go to IDLE, reload cooldown, no shot.
  - Worst-case latency PICK to ISSUE: N_ENEMY+1 cycles.
- ISSUE:
  - fire_valid = 1; fire_id stays stable until accepted.
  - Handshake completes on fire_valid & fire_ready.
  - On handshake, next cycle: fire_valid = 0, ID_enemy_tiro[fire_id] = 1 for exactly one cycle, active_shots++, reload cooldown, go to IDLE.
  - Request is never retracted: enemy dying or enable dropping during ISSUE does not cancel it.
- enable = 0 in PICK/SCAN: abort to IDLE; cooldown stays 0, so the pick retries when enable returns.
- Slot accounting, per cycle:
  - Handshake and bullet_done in the same cycle: count unchanged.
  - bullet_done with count 0: ignored.
  - Count never exceeds N_SLOTS.
- reset in any state, including mid-ISSUE: immediate return to reset values; pending request dropped.

Optional Feature:
- Macro: ADAPTIVE_RATE_EN.
- Defined: on each reload, kills = N_ENEMY − popcount(enemy_vivos); reload = max(RATE_MIN, ATRASO_TIRO − kills*RATE_STEP), computed without underflow. Reset value stays ATRASO_TIRO.
- Undefined: reload is always ATRASO_TIRO.

Test Plan (bench params: N_ENEMY=8, ATRASO_TIRO=8, N_SLOTS=2):
- Reset, all alive, enable=1, fire_ready=1 → fire_valid first rises 11 cycles after reset release (8 cooldown + IDLE→PICK + PICK + SCAN); fire_id = (LFSR % 8) at PICK; one-cycle ID_enemy_tiro pulse at that index; active_shots=1.
- Only enemy 5 alive (8'b0010_0000), any seed → every issued fire_id = 5; enemy_vivos=0 → no fire_valid over 100 cycles; cooldown reloads after each 8-cycle scan.
- fire_ready held low 20 cycles in ISSUE, enemy killed meanwhile → fire_valid and fire_id stable for 20 cycles; shot accepted when ready rises.
- No bullet_done for 3 cooldown periods → exactly 2 shots, then fire_valid stays 0; one bullet_done pulse → third shot after the next PICK/SCAN.
- Handshake and bullet_done in the same cycle with active_shots=1 → active_shots stays 1; bullet_done at 0 → stays 0.
- enable=0 mid-SCAN → IDLE, cooldown frozen; reset asserted during ISSUE → fire_valid=0, active_shots=0 next cycle. With ADAPTIVE_RATE_EN, ATRASO_TIRO=100, RATE_STEP=10, RATE_MIN=40, 3 dead → reload 70; 7 dead → reload 40.
